// File: rtl/ad9361_dual_axis_tx.sv
// AXI-stream to AD9361 TX sample unpacker: 128-bit 4-channel I/Q words are buffered and released per data_req.
// Define AD9361_DUAL_AXIS_TX_SATURATE_EN to clamp each 16-bit lane to the signed 12-bit range instead of truncating.
module ad9361_dual_axis_tx #(
  parameter int unsigned REVERSE_DATA      = 0,
  parameter int unsigned USE_AXIS_TLAST    = 0,
  parameter int unsigned AXIS_BURST_LENGTH = 512,
  parameter int unsigned FIFO_DEPTH        = 8,
  parameter int unsigned PRIME_LEVEL       = 4
) (
  input  logic                        data_clk,
  input  logic                        data_resetn,
  input  logic                        enable,
  input  logic                        clr_status,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
  input  logic [127:0]                s_axis_tdata,
  input  logic                        data_req,
  output logic                        valid_0,
  output logic                        valid_1,
  output logic                        valid_2,
  output logic                        valid_3,
  output logic [11:0]                 data_i0,
  output logic [11:0]                 data_q0,
  output logic [11:0]                 data_i1,
  output logic [11:0]                 data_q1,
  output logic [11:0]                 data_i2,
  output logic [11:0]                 data_q2,
  output logic [11:0]                 data_i3,
  output logic [11:0]                 data_q3,
  output logic                        underflow,
  output logic                        tlast_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned CW    = (AXIS_BURST_LENGTH > 1) ? $clog2(AXIS_BURST_LENGTH) : 1;
  localparam int unsigned NLANE = 8;
  localparam int unsigned LANE_W = 16;
  localparam int unsigned SMP_W  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [127:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [127:0]   rd_word;
  logic [CW-1:0]  beat_cnt;
  logic           beat_last;

  logic           push;
  logic           pop;
  logic           flush;
  logic           underflow_evt;
  logic           tlast_evt;

  logic [SMP_W-1:0] lane_12  [NLANE];
  logic [SMP_W-1:0] sample_q [NLANE];
  logic             sample_valid;

  assign s_axis_tready = (state != ST_IDLE) && (fifo_level < LW'(FIFO_DEPTH));
  assign rd_word       = mem[rd_ptr];
  assign beat_last     = (beat_cnt == CW'(AXIS_BURST_LENGTH - 1));

  // State register
  always_ff @(posedge data_clk) begin
    if (!data_resetn) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  // Next state and per-cycle FIFO/flag events
  always_comb begin
    state_nxt     = state;
    push          = 1'b0;
    pop           = 1'b0;
    flush         = 1'b0;
    underflow_evt = 1'b0;
    tlast_evt     = 1'b0;

    push = s_axis_tvalid && s_axis_tready;

    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_PRIME;
      end
      ST_PRIME: begin
        if (fifo_level >= LW'(PRIME_LEVEL)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (data_req && enable) begin
          if (fifo_level != '0) begin
            pop = 1'b1;
          end else begin
            underflow_evt = 1'b1;
            state_nxt     = ST_PRIME;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (!enable) state_nxt = ST_IDLE;
    flush = (state_nxt == ST_IDLE);

    if (USE_AXIS_TLAST != 0) tlast_evt = push && (s_axis_tlast != beat_last);
  end

  // FIFO pointers and occupancy; a flush discards everything including a same-cycle push
  always_ff @(posedge data_clk) begin
    if (!data_resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Word storage carries no reset; pointers define what is valid
  always_ff @(posedge data_clk) begin
    if (push) mem[wr_ptr] <= s_axis_tdata;
  end

`ifdef AD9361_DUAL_AXIS_TX_SATURATE_EN
  function automatic logic [SMP_W-1:0] lane_to_12(input logic [LANE_W-1:0] lane);
    if ($signed(lane) > 16'sd2047)       return 12'h7FF;
    else if ($signed(lane) < -16'sd2048) return 12'h800;
    else                                 return lane[SMP_W-1:0];
  endfunction

  always_comb begin
    for (int j = 0; j < NLANE; j++) begin
      if (REVERSE_DATA != 0) lane_12[j] = lane_to_12(rd_word[LANE_W*j +: LANE_W]);
      else                   lane_12[j] = lane_to_12(rd_word[LANE_W*(NLANE-1-j) +: LANE_W]);
    end
  end
`else
  logic [4*NLANE-1:0] unused_lane_hi;

  // Plain truncation: the top nibble of each lane is dropped
  always_comb begin
    unused_lane_hi = '0;
    for (int j = 0; j < NLANE; j++) begin
      unused_lane_hi[4*j +: 4] = rd_word[LANE_W*j+SMP_W +: 4];
      if (REVERSE_DATA != 0) lane_12[j] = rd_word[LANE_W*j +: SMP_W];
      else                   lane_12[j] = rd_word[LANE_W*(NLANE-1-j) +: SMP_W];
    end
  end
`endif

  // Sample output registers: strobe follows data_req by one cycle, data holds between requests
  always_ff @(posedge data_clk) begin
    if (!data_resetn) begin
      sample_valid <= 1'b0;
      for (int j = 0; j < NLANE; j++) sample_q[j] <= '0;
    end else begin
      sample_valid <= data_req;
      if (data_req) begin
        for (int j = 0; j < NLANE; j++) sample_q[j] <= pop ? lane_12[j] : '0;
      end
    end
  end

  // Beat counter: resyncs on tlast, clears whenever the block drops to IDLE
  always_ff @(posedge data_clk) begin
    if (!data_resetn) begin
      beat_cnt <= '0;
    end else if (state_nxt == ST_IDLE) begin
      beat_cnt <= '0;
    end else if (push) begin
      if (s_axis_tlast || beat_last) beat_cnt <= '0;
      else                           beat_cnt <= beat_cnt + CW'(1);
    end
  end

  // Sticky flags; a new event wins over a same-cycle clear
  always_ff @(posedge data_clk) begin
    if (!data_resetn) begin
      underflow <= 1'b0;
      tlast_err <= 1'b0;
    end else begin
      underflow <= underflow_evt || (underflow && !clr_status);
      tlast_err <= tlast_evt     || (tlast_err && !clr_status);
    end
  end

  assign valid_0 = sample_valid;
  assign valid_1 = sample_valid;
  assign valid_2 = sample_valid;
  assign valid_3 = sample_valid;
  assign data_i0 = sample_q[0];
  assign data_q0 = sample_q[1];
  assign data_i1 = sample_q[2];
  assign data_q1 = sample_q[3];
  assign data_i2 = sample_q[4];
  assign data_q2 = sample_q[5];
  assign data_i3 = sample_q[6];
  assign data_q3 = sample_q[7];

endmodule

// File: tb/tb_ad9361_dual_axis_tx.sv
// Bench for ad9361_dual_axis_tx: two configurations share one stimulus stream and are checked
// against a queue-based reference model every cycle, plus directed scenario checks.
module tb_ad9361_dual_axis_tx;

  localparam int DEPTH = 8;

  logic         data_clk;
  logic         data_resetn;
  logic         enable;
  logic         clr_status;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic [127:0] s_axis_tdata;
  logic         data_req;

  logic        rdy0, uf0, te0;
  logic        v0 [4];
  logic [11:0] d0 [8];
  logic [3:0]  lv0;
  logic        rdy1, uf1, te1;
  logic        v1 [4];
  logic [11:0] d1 [8];
  logic [3:0]  lv1;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state, index 0 = default config, 1 = reversed lanes with tlast checking
  int           ms   [2];
  int           mcnt [2];
  bit           muf  [2];
  bit           mte  [2];
  bit           mval [2];
  int           mdat [2][8];
  logic [127:0] mq0 [$];
  logic [127:0] mq1 [$];

  ad9361_dual_axis_tx u_dut0 (
    .data_clk(data_clk), .data_resetn(data_resetn), .enable(enable), .clr_status(clr_status),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(rdy0), .s_axis_tlast(s_axis_tlast),
    .s_axis_tdata(s_axis_tdata), .data_req(data_req),
    .valid_0(v0[0]), .valid_1(v0[1]), .valid_2(v0[2]), .valid_3(v0[3]),
    .data_i0(d0[0]), .data_q0(d0[1]), .data_i1(d0[2]), .data_q1(d0[3]),
    .data_i2(d0[4]), .data_q2(d0[5]), .data_i3(d0[6]), .data_q3(d0[7]),
    .underflow(uf0), .tlast_err(te0), .fifo_level(lv0)
  );

  ad9361_dual_axis_tx #(
    .REVERSE_DATA(1), .USE_AXIS_TLAST(1), .AXIS_BURST_LENGTH(4), .FIFO_DEPTH(8), .PRIME_LEVEL(2)
  ) u_dut1 (
    .data_clk(data_clk), .data_resetn(data_resetn), .enable(enable), .clr_status(clr_status),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(rdy1), .s_axis_tlast(s_axis_tlast),
    .s_axis_tdata(s_axis_tdata), .data_req(data_req),
    .valid_0(v1[0]), .valid_1(v1[1]), .valid_2(v1[2]), .valid_3(v1[3]),
    .data_i0(d1[0]), .data_q0(d1[1]), .data_i1(d1[2]), .data_q1(d1[3]),
    .data_i2(d1[4]), .data_q2(d1[5]), .data_i3(d1[6]), .data_q3(d1[7]),
    .underflow(uf1), .tlast_err(te1), .fifo_level(lv1)
  );

  initial data_clk = 1'b0;
  always #5 data_clk = ~data_clk;

  function automatic int p_rev(input int k);   return (k == 0) ? 0 : 1; endfunction
  function automatic int p_tl(input int k);    return (k == 0) ? 0 : 1; endfunction
  function automatic int p_bl(input int k);    return (k == 0) ? 512 : 4; endfunction
  function automatic int p_prime(input int k); return (k == 0) ? 4 : 2; endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  // Expected 12-bit sample for channel slot j (i0,q0,i1,...,q3) of a word
  function automatic int exp_lane(input logic [127:0] w, input int j, input int rev);
    int pos, v, s;
    logic [127:0] sh;
    pos = rev ? j : 7 - j;
    sh  = w >> (16 * pos);
    v   = int'(sh[15:0]);
    s   = (v >= 32768) ? v - 65536 : v;
`ifdef AD9361_DUAL_AXIS_TX_SATURATE_EN
    if (s > 2047)  return 'h7FF;
    if (s < -2048) return 'h800;
`endif
    return v % 4096;
  endfunction

  function automatic logic good_tl();
    return mcnt[1] == p_bl(1) - 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input int k, input logic rn, input logic en, input logic clr,
                            input logic tv, input logic tl, input logic [127:0] td, input logic rq);
    int lvl, nxt;
    bit push, pop, uf_evt, te_evt, last;
    logic [127:0] w;
    if (!rn) begin
      ms[k] = 0; mcnt[k] = 0; muf[k] = 0; mte[k] = 0; mval[k] = 0;
      for (int j = 0; j < 8; j++) mdat[k][j] = 0;
      if (k == 0) mq0.delete(); else mq1.delete();
      return;
    end
    lvl    = qsize(k);
    push   = tv && (ms[k] != 0) && (lvl < DEPTH);
    pop    = en && (ms[k] == 2) && rq && (lvl > 0);
    uf_evt = en && (ms[k] == 2) && rq && (lvl == 0);
    last   = (mcnt[k] == p_bl(k) - 1);
    te_evt = (p_tl(k) != 0) && push && (tl != last);
    mval[k] = rq;
    if (rq) begin
      w = '0;
      if (pop) w = (k == 0) ? mq0.pop_front() : mq1.pop_front();
      for (int j = 0; j < 8; j++) mdat[k][j] = pop ? exp_lane(w, j, p_rev(k)) : 0;
    end
    if (push) begin
      if (k == 0) mq0.push_back(td); else mq1.push_back(td);
    end
    muf[k] = uf_evt || (muf[k] && !clr);
    mte[k] = te_evt || (mte[k] && !clr);
    nxt = ms[k];
    if (ms[k] == 0) nxt = 1;
    else if (ms[k] == 1 && lvl >= p_prime(k)) nxt = 2;
    else if (uf_evt) nxt = 1;
    if (!en) nxt = 0;
    if (nxt == 0) begin
      if (k == 0) mq0.delete(); else mq1.delete();
      mcnt[k] = 0;
    end else if (push) begin
      mcnt[k] = (tl || last) ? 0 : mcnt[k] + 1;
    end
    ms[k] = nxt;
  endtask

  task automatic compare_k(input int k);
    logic [11:0] gd [8];
    logic        gv [4];
    logic        grdy, guf, gte;
    logic [3:0]  glv;
    if (k == 0) begin gd = d0; gv = v0; grdy = rdy0; guf = uf0; gte = te0; glv = lv0; end
    else        begin gd = d1; gv = v1; grdy = rdy1; guf = uf1; gte = te1; glv = lv1; end
    check($sformatf("u%0d_tready", k), 32'(grdy), 32'((ms[k] != 0) && (qsize(k) < DEPTH)));
    check($sformatf("u%0d_level", k), 32'(glv), 32'(qsize(k)));
    for (int j = 0; j < 4; j++) check($sformatf("u%0d_valid%0d", k, j), 32'(gv[j]), 32'(mval[k]));
    for (int j = 0; j < 8; j++) check($sformatf("u%0d_data%0d", k, j), 32'(gd[j]), 32'(mdat[k][j]));
    check($sformatf("u%0d_underflow", k), 32'(guf), 32'(muf[k]));
    check($sformatf("u%0d_tlast_err", k), 32'(gte), 32'(mte[k]));
  endtask

  // One clock: check current outputs, drive the next inputs, advance the model across the edge
  task automatic cycle(input logic rn, input logic en, input logic clr, input logic tv,
                       input logic tl, input logic [127:0] td, input logic rq);
    compare_k(0);
    compare_k(1);
    data_resetn   = rn;
    enable        = en;
    clr_status    = clr;
    s_axis_tvalid = tv;
    s_axis_tlast  = tl;
    s_axis_tdata  = td;
    data_req      = rq;
    model_step(0, rn, en, clr, tv, tl, td, rq);
    model_step(1, rn, en, clr, tv, tl, td, rq);
    @(posedge data_clk);
    @(negedge data_clk);
  endtask

  function automatic logic [127:0] rand_word();
    logic [127:0] w;
    logic [15:0]  ln;
    w = '0;
    for (int j = 0; j < 8; j++) begin
      ln = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0: ln = 16'h07FF;
          1: ln = 16'h0800;
          2: ln = 16'hF7FF;
          3: ln = 16'hF800;
          4: ln = 16'h0900;
          default: ln = 16'hF000;
        endcase
      end
      w[16*j +: 16] = ln;
    end
    return w;
  endfunction

  initial begin
    logic [127:0] w1, w2;
    int pv, pr;
    data_resetn = 1'b0; enable = 1'b0; clr_status = 1'b0; s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0; s_axis_tdata = '0; data_req = 1'b0;
    model_step(0, 1'b0, 0, 0, 0, 0, '0, 0);
    model_step(1, 1'b0, 0, 0, 0, 0, '0, 0);
    repeat (2) @(posedge data_clk);
    @(negedge data_clk);

    // Prime with four words, then one request yields the first word
    w1 = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
    cycle(1, 1, 0, 0, 0, '0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 1, good_tl(), (i == 0) ? w1 : rand_word(), 0);
    cycle(1, 1, 0, 0, 0, '0, 0);
    cycle(1, 1, 0, 0, 0, '0, 1);
    check("tp_i0", 32'(d0[0]), 32'h001);
    check("tp_q0", 32'(d0[1]), 32'h002);
    check("tp_q3", 32'(d0[7]), 32'h008);
    check("tp_rev_i0", 32'(d1[0]), 32'h008);
    check("tp_rev_q3", 32'(d1[7]), 32'h001);
    check("tp_valid", 32'(v0[2]), 32'h1);

    // Fill to full, then a request with tvalid high pops without pushing
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 1, good_tl(), rand_word(), 0);
    check("full_level", 32'(lv0), 32'd8);
    check("full_tready", 32'(rdy0), 32'h0);
    cycle(1, 1, 0, 1, good_tl(), rand_word(), 1);
    check("full_pop_level", 32'(lv0), 32'd7);

    // Drain, then underflow on an empty request, then clear it
    for (int i = 0; i < 7; i++) cycle(1, 1, 0, 0, 0, '0, 1);
    cycle(1, 1, 0, 0, 0, '0, 1);
    check("uf_flag", 32'(uf0), 32'h1);
    check("uf_valid", 32'(v0[0]), 32'h1);
    check("uf_i0_zero", 32'(d0[0]), 32'h0);
    cycle(1, 1, 1, 0, 0, '0, 0);
    check("uf_clear", 32'(uf0), 32'h0);

    // tlast early on beat 2 flags, resync makes the next full burst clean
    cycle(1, 1, 0, 1, 1, rand_word(), 0);
    cycle(1, 1, 1, 0, 0, '0, 0);
    cycle(1, 1, 0, 1, 0, rand_word(), 0);
    cycle(1, 1, 0, 1, 1, rand_word(), 0);
    check("tlast_early", 32'(te1), 32'h1);
    cycle(1, 1, 1, 0, 0, '0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 1, (i == 3), rand_word(), 0);
    check("tlast_resync", 32'(te1), 32'h0);
    check("tlast_unused", 32'(te0), 32'h0);

    // Dropping enable flushes the queue
    cycle(1, 0, 0, 1, 0, rand_word(), 0);
    check("dis_level", 32'(lv0), 32'd0);
    check("dis_tready", 32'(rdy0), 32'h0);
    cycle(1, 0, 0, 0, 0, '0, 1);
    check("dis_valid", 32'(v0[1]), 32'h1);
    check("dis_zero", 32'(d0[3]), 32'h0);

    // Saturation/truncation corner lanes
    w2 = 128'h0900_F000_0123_0456_0789_0ABC_0DEF_0111;
    cycle(1, 1, 0, 0, 0, '0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 1, good_tl(), (i == 0) ? w2 : rand_word(), 0);
    cycle(1, 1, 0, 0, 0, '0, 0);
    cycle(1, 1, 0, 0, 0, '0, 1);
`ifdef AD9361_DUAL_AXIS_TX_SATURATE_EN
    check("sat_pos", 32'(d0[0]), 32'h7FF);
    check("sat_neg", 32'(d0[1]), 32'h800);
`else
    check("trunc_pos", 32'(d0[0]), 32'h900);
    check("trunc_neg", 32'(d0[1]), 32'h000);
`endif

    // Randomized traffic with varying densities, occasional disables, clears and resets
    for (int seg = 0; seg < 20; seg++) begin
      pv = $urandom_range(10, 100);
      pr = $urandom_range(5, 100);
      for (int i = 0; i < 200; i++) begin
        logic tl;
        tl = good_tl() ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
        cycle(($urandom_range(0, 499) != 0), ($urandom_range(0, 149) != 0),
              ($urandom_range(0, 30) == 0), ($urandom_range(1, 100) <= pv), tl,
              rand_word(), ($urandom_range(1, 100) <= pr));
      end
    end
    compare_k(0);
    compare_k(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
